chip8_sprite_writer: RTL and testbench

//  Write side of the CHIP-8 64x32 1bpp framebuffer. The scan-out path reads this buffer.

---
 rtl/chip8_sprite_writer_if.sv | 31 +++
 rtl/chip8_sprite_writer.sv | 163 ++++++++++++++++
 tb/tb_chip8_sprite_writer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_sprite_writer_if.sv
// Bundle between the CHIP-8 sprite writer and its surroundings: the command
// inputs, the sprite-memory read port, the framebuffer read/write port and status.
interface chip8_sprite_writer_if #(
   parameter int MEM_AW = 12
);
   logic              start;
   logic              clr;
   logic [5:0]        x;
   logic [4:0]        y;
   logic [3:0]        n;
   logic [MEM_AW-1:0] i_base;
   logic [MEM_AW-1:0] spr_addr;
   logic [7:0]        spr_data;
   logic [7:0]        fb_addr;
   logic [7:0]        fb_rdata;
   logic [7:0]        fb_wdata;
   logic              fb_we;
   logic              busy;
   logic              done;
   logic              collision;

   modport slave (
      input  start, clr, x, y, n, i_base, spr_data, fb_rdata,
      output spr_addr, fb_addr, fb_wdata, fb_we, busy, done, collision
   );

   modport master (
      output start, clr, x, y, n, i_base, spr_data, fb_rdata,
      input  spr_addr, fb_addr, fb_wdata, fb_we, busy, done, collision
   );
endinterface

// File: rtl/chip8_sprite_writer.sv
// CHIP-8 framebuffer writer: DXYN sprite draw by read-modify-write XOR with
// collision detection, and 00E0 screen clear. 64x32 1bpp, byte = row*8 + col/8,
// bit 7 is the leftmost pixel of a byte.
module chip8_sprite_writer #(
   parameter int MEM_AW = 12,
   parameter bit WRAP_X = 1'b1,
   parameter bit WRAP_Y = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   chip8_sprite_writer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SPR_REQ, S_SPR_LAT, S_L_WR, S_R_REQ, S_R_WR, S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [5:0]        r_x;
   logic [4:0]        r_y;
   logic [3:0]        r_n;
   logic [MEM_AW-1:0] r_base;
   logic [3:0]        r_row;
   logic [7:0]        r_spr;
   logic [7:0]        r_clr_cnt;
   logic              r_coll;

   logic [2:0]        w_sh;
   logic [4:0]        w_fb_row;
   logic [7:0]        w_addr_l;
   logic [7:0]        w_addr_r;
   logic [7:0]        w_mask_l;
   logic [7:0]        w_mask_r;
   logic              w_need_r;
   logic              w_last_row;
   logic [MEM_AW-1:0] w_spr_addr;
   logic [7:0]        w_fb_addr;
   logic [7:0]        w_fb_wdata;
   logic              w_fb_we;
   logic              w_busy;
   logic              w_done;

   assign w_sh     = r_x[2:0];
   assign w_fb_row = r_y + 5'(r_row);
   assign w_addr_l = {w_fb_row, r_x[5:3]};
   assign w_addr_r = {w_fb_row, r_x[5:3] + 3'd1};
   assign w_mask_l = r_spr >> w_sh;
   assign w_mask_r = r_spr << (4'd8 - {1'b0, w_sh});
   // The right-hand byte exists only when the sprite straddles a byte boundary,
   // and with clipping it is dropped when the left byte is already the last column.
   assign w_need_r = (w_sh != 3'd0) && (WRAP_X || (r_x[5:3] != 3'd7));
   assign w_last_row = (r_row == (r_n - 4'd1)) ||
                       (!WRAP_Y && (({1'b0, r_y} + {2'b00, r_row} + 6'd1) > 6'd31));

   assign bus.spr_addr  = w_spr_addr;
   assign bus.fb_addr   = w_fb_addr;
   assign bus.fb_wdata  = w_fb_wdata;
   assign bus.fb_we     = w_fb_we;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.collision = r_coll;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode and per-state memory port drive.
   always_comb begin
      w_next     = r_state;
      w_spr_addr = '0;
      w_fb_addr  = '0;
      w_fb_wdata = '0;
      w_fb_we    = 1'b0;
      w_busy     = 1'b1;
      w_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.clr)        w_next = S_CLEAR;
            else if (bus.start) w_next = (bus.n == 4'd0) ? S_DONE : S_SPR_REQ;
         end
         S_CLEAR: begin
            w_fb_we   = 1'b1;
            w_fb_addr = r_clr_cnt;
            if (r_clr_cnt == 8'hFF) w_next = S_DONE;
         end
         S_SPR_REQ: begin
            w_spr_addr = r_base + MEM_AW'(r_row);
            w_next     = S_SPR_LAT;
         end
         S_SPR_LAT: begin
            w_fb_addr = w_addr_l;
            w_next    = S_L_WR;
         end
         S_L_WR: begin
            w_fb_we    = 1'b1;
            w_fb_addr  = w_addr_l;
            w_fb_wdata = bus.fb_rdata ^ w_mask_l;
            if (w_need_r)        w_next = S_R_REQ;
            else if (w_last_row) w_next = S_DONE;
            else                 w_next = S_SPR_REQ;
         end
         S_R_REQ: begin
            w_fb_addr = w_addr_r;
            w_next    = S_R_WR;
         end
         S_R_WR: begin
            w_fb_we    = 1'b1;
            w_fb_addr  = w_addr_r;
            w_fb_wdata = bus.fb_rdata ^ w_mask_r;
            w_next     = w_last_row ? S_DONE : S_SPR_REQ;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Command latch, sprite byte, row/clear counters and collision flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x       <= '0;
         r_y       <= '0;
         r_n       <= '0;
         r_base    <= '0;
         r_row     <= '0;
         r_spr     <= '0;
         r_clr_cnt <= '0;
         r_coll    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_clr_cnt <= '0;
               if (!bus.clr && bus.start) begin
                  r_x    <= bus.x;
                  r_y    <= bus.y;
                  r_n    <= bus.n;
                  r_base <= bus.i_base;
                  r_row  <= '0;
                  r_coll <= 1'b0;
               end
            end
            S_CLEAR:   r_clr_cnt <= r_clr_cnt + 8'd1;
            S_SPR_LAT: r_spr     <= bus.spr_data;
            S_L_WR: begin
               r_coll <= r_coll | (|(bus.fb_rdata & w_mask_l));
               if (!w_need_r) r_row <= r_row + 4'd1;
            end
            S_R_WR: begin
               r_coll <= r_coll | (|(bus.fb_rdata & w_mask_r));
               r_row  <= r_row + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_sprite_writer.sv
// Scoreboard bench for chip8_sprite_writer: one wrapping instance (A) and one
// clipping instance (B), each with its own sprite/framebuffer memory models.
module tb_chip8_sprite_writer;

   typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
   typedef struct packed { logic coll; logic [15:0] lat; } dn_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   chip8_sprite_writer_if #(.MEM_AW(12)) ifa ();
   chip8_sprite_writer_if #(.MEM_AW(12)) ifb ();

   chip8_sprite_writer #(.MEM_AW(12), .WRAP_X(1'b1), .WRAP_Y(1'b1)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa.slave));
   chip8_sprite_writer #(.MEM_AW(12), .WRAP_X(1'b0), .WRAP_Y(1'b0)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb.slave));

   logic [7:0] smem [0:4095];
   logic [7:0] fba  [0:255];
   logic [7:0] fbb  [0:255];

   int  checks = 0;
   int  failures = 0;
   int  bcnt [2];
   int  ndone [2];
   wr_t wqa [$];
   wr_t wqb [$];
   dn_t dqa [$];
   dn_t dqb [$];

   always #5 clk = ~clk;

   // Synchronous sprite memory and read-before-write framebuffers.
   always @(posedge clk) begin
      ifa.spr_data <= smem[ifa.spr_addr];
      ifb.spr_data <= smem[ifb.spr_addr];
      if (ifa.fb_we === 1'b1) fba[ifa.fb_addr] <= ifa.fb_wdata;
      if (ifb.fb_we === 1'b1) fbb[ifb.fb_addr] <= ifb.fb_wdata;
      ifa.fb_rdata <= fba[ifa.fb_addr];
      ifb.fb_rdata <= fbb[ifb.fb_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_wr(input int id, input logic [7:0] a, input logic [7:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      if (id == 0) wqa.push_back(e);
      else         wqb.push_back(e);
   endtask

   task automatic push_dn(input int id, input logic coll, input logic [15:0] lat);
      dn_t f;
      f.coll = coll;
      f.lat  = lat;
      if (id == 0) dqa.push_back(f);
      else         dqb.push_back(f);
   endtask

   task automatic mon(input int id, input logic we, input logic [7:0] a, input logic [7:0] d,
                      input logic bsy, input logic dn, input logic coll);
      wr_t e;
      dn_t f;
      logic got;
      if (bsy === 1'b1) bcnt[id]++;
      else              bcnt[id] = 0;
      if (we === 1'b1) begin
         checks++;
         got = 1'b0;
         if (id == 0 && wqa.size() > 0) begin e = wqa.pop_front(); got = 1'b1; end
         if (id == 1 && wqb.size() > 0) begin e = wqb.pop_front(); got = 1'b1; end
         if (!got) begin
            failures++;
            $display("FAIL wr%0d unexpected write actual addr=%0d data=%h", id, a, d);
         end else if (e.a !== a || e.d !== d) begin
            failures++;
            $display("FAIL wr%0d actual addr=%0d data=%h required addr=%0d data=%h",
                     id, a, d, e.a, e.d);
         end
      end
      if (dn === 1'b1) begin
         checks++;
         ndone[id]++;
         got = 1'b0;
         if (id == 0 && dqa.size() > 0) begin f = dqa.pop_front(); got = 1'b1; end
         if (id == 1 && dqb.size() > 0) begin f = dqb.pop_front(); got = 1'b1; end
         if (!got) begin
            failures++;
            $display("FAIL done%0d unexpected done actual coll=%0d lat=%0d", id, coll, bcnt[id]);
         end else if (f.coll !== coll || int'(f.lat) != bcnt[id]) begin
            failures++;
            $display("FAIL done%0d actual coll=%0d lat=%0d required coll=%0d lat=%0d",
                     id, coll, bcnt[id], f.coll, f.lat);
         end
      end
   endtask

   // Monitor: compares every write and done pulse against the scoreboards.
   always @(negedge clk) begin
      mon(0, ifa.fb_we, ifa.fb_addr, ifa.fb_wdata, ifa.busy, ifa.done, ifa.collision);
      mon(1, ifb.fb_we, ifb.fb_addr, ifb.fb_wdata, ifb.busy, ifb.done, ifb.collision);
   end

   task automatic cmd(input int id, input logic c, input logic s, input logic [5:0] x,
                      input logic [4:0] y, input logic [3:0] n, input logic [11:0] ib);
      @(negedge clk);
      if (id == 0) begin
         ifa.clr = c; ifa.start = s; ifa.x = x; ifa.y = y; ifa.n = n; ifa.i_base = ib;
      end else begin
         ifb.clr = c; ifb.start = s; ifb.x = x; ifb.y = y; ifb.n = n; ifb.i_base = ib;
      end
      @(negedge clk);
      if (id == 0) begin ifa.clr = 1'b0; ifa.start = 1'b0; end
      else         begin ifb.clr = 1'b0; ifb.start = 1'b0; end
   endtask

   task automatic wait_done(input int id, input int target);
      for (int k = 0; k < 600 && ndone[id] < target; k++) begin
         @(negedge clk);
         #1;
      end
      chk($sformatf("done_wait%0d_%0d", id, target), 32'(ndone[id] >= target), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) smem[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin fba[i] = 8'h00; fbb[i] = 8'h00; end
      smem[12'h200] = 8'hF0;
      smem[12'h201] = 8'hFF;
      smem[12'h202] = 8'hFF;
      smem[12'h203] = 8'hFF;
      smem[12'h204] = 8'hFF;
      bcnt[0] = 0; bcnt[1] = 0; ndone[0] = 0; ndone[1] = 0;
      ifa.clr = 1'b0; ifa.start = 1'b0; ifa.x = '0; ifa.y = '0; ifa.n = '0; ifa.i_base = '0;
      ifb.clr = 1'b0; ifb.start = 1'b0; ifb.x = '0; ifb.y = '0; ifb.n = '0; ifb.i_base = '0;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_spr_addr", 32'(ifa.spr_addr), 32'd0);
      chk("rst_fb_addr", 32'(ifa.fb_addr), 32'd0);
      chk("rst_fb_wdata", 32'(ifa.fb_wdata), 32'd0);
      chk("rst_fb_we", 32'(ifa.fb_we), 32'd0);
      chk("rst_busy", 32'(ifa.busy), 32'd0);
      chk("rst_done", 32'(ifa.done), 32'd0);
      chk("rst_collision", 32'(ifa.collision), 32'd0);
      reset = 1'b0;

      // clear, then single byte at origin
      for (int k = 0; k < 256; k++) push_wr(0, 8'(k), 8'h00);
      push_dn(0, 1'b0, 16'd257);
      cmd(0, 1'b1, 1'b0, 6'd0, 5'd0, 4'd0, 12'h000);
      wait_done(0, 1);
      push_wr(0, 8'd0, 8'hF0);
      push_dn(0, 1'b0, 16'd4);
      cmd(0, 1'b0, 1'b1, 6'd0, 5'd0, 4'd1, 12'h200);
      wait_done(0, 2);
      chk("fb0_after_draw", 32'(fba[0]), 32'hF0);

      // same draw erases and collides
      push_wr(0, 8'd0, 8'h00);
      push_dn(0, 1'b1, 16'd4);
      cmd(0, 1'b0, 1'b1, 6'd0, 5'd0, 4'd1, 12'h200);
      wait_done(0, 3);
      chk("fb0_after_erase", 32'(fba[0]), 32'h00);

      // straddling byte; a start while busy is ignored
      push_wr(0, 8'd16, 8'h1F);
      push_wr(0, 8'd17, 8'hE0);
      push_dn(0, 1'b0, 16'd6);
      cmd(0, 1'b0, 1'b1, 6'd3, 5'd2, 4'd1, 12'h201);
      ifa.start = 1'b1; ifa.n = 4'd0;
      @(negedge clk);
      ifa.start = 1'b0;
      wait_done(0, 4);
      chk("fb16", 32'(fba[16]), 32'h1F);
      chk("fb17", 32'(fba[17]), 32'hE0);

      // corner draw with wrap in both directions
      push_wr(0, 8'd247, 8'h0F); push_wr(0, 8'd240, 8'hF0);
      push_wr(0, 8'd255, 8'h0F); push_wr(0, 8'd248, 8'hF0);
      push_wr(0, 8'd7,   8'h0F); push_wr(0, 8'd0,   8'hF0);
      push_dn(0, 1'b0, 16'd16);
      cmd(0, 1'b0, 1'b1, 6'd60, 5'd30, 4'd3, 12'h202);
      wait_done(0, 5);

      // same corner draw with clipping
      push_wr(1, 8'd247, 8'h0F);
      push_wr(1, 8'd255, 8'h0F);
      push_dn(1, 1'b0, 16'd7);
      cmd(1, 1'b0, 1'b1, 6'd60, 5'd30, 4'd3, 12'h202);
      wait_done(1, 1);
      chk("fbb7_untouched", 32'(fbb[7]), 32'h00);

      // collide, then clr+start: clear wins and keeps collision
      push_wr(0, 8'd0, 8'h00);
      push_dn(0, 1'b1, 16'd4);
      cmd(0, 1'b0, 1'b1, 6'd0, 5'd0, 4'd1, 12'h200);
      wait_done(0, 6);
      for (int k = 0; k < 256; k++) push_wr(0, 8'(k), 8'h00);
      push_dn(0, 1'b1, 16'd257);
      cmd(0, 1'b1, 1'b1, 6'd0, 5'd0, 4'd1, 12'h200);
      wait_done(0, 7);

      // n=0 draw clears collision and writes nothing
      push_dn(0, 1'b0, 16'd1);
      cmd(0, 1'b0, 1'b1, 6'd5, 5'd5, 4'd0, 12'h200);
      wait_done(0, 8);

      // reset in the second clear cycle aborts
      push_wr(0, 8'd0, 8'h00);
      push_wr(0, 8'd1, 8'h00);
      cmd(0, 1'b1, 1'b0, 6'd0, 5'd0, 4'd0, 12'h000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_fb_we", 32'(ifa.fb_we), 32'd0);
      chk("abort_busy", 32'(ifa.busy), 32'd0);
      chk("abort_done", 32'(ifa.done), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("abort_no_done", 32'(ndone[0]), 32'd8);
      chk("wqa_empty", 32'(wqa.size()), 32'd0);
      chk("dqa_empty", 32'(dqa.size()), 32'd0);
      chk("wqb_empty", 32'(wqb.size()), 32'd0);
      chk("dqb_empty", 32'(dqb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
